// File: rtl/alu_pkg.sv
// Shared constants and command type for the ALU issue block.
// Function codes 110/111 are reserved and reported through out_err.
package alu_pkg;

    localparam int DEPTH_DEFAULT = 4;
    localparam int DATA_W        = 32;
    localparam int FUNC_W        = 3;

    localparam logic [FUNC_W-1:0] ADD = 3'b000;
    localparam logic [FUNC_W-1:0] INC = 3'b001;
    localparam logic [FUNC_W-1:0] SUB = 3'b010;
    localparam logic [FUNC_W-1:0] DEC = 3'b011;
    localparam logic [FUNC_W-1:0] MUL = 3'b100;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [FUNC_W-1:0] f;
        logic              use_prev;
    } cmd_t;

    // MUL occupies both 100 and 101; only the top two bits select it.
    function automatic logic f_is_legal(input logic [FUNC_W-1:0] f);
        logic ok;
        case (f)
            ADD, INC, SUB, DEC: ok = 1'b1;
            default:            ok = (f[2:1] == MUL[2:1]);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Synchronous FIFO holding queued ALU commands; pointers wrap naturally
// because DEPTH is a power of two.
module alu_issue_fifo
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Guards make the FIFO safe even if a caller ignores full/empty.
    assign do_push = push_i && (count_q != CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Command queue in front of an external combinational ALU with a registered
// result stage. Define ALU_ISSUE_FWD_EN to let a command take operand a from the previous ALU result.
module alu_issue
    import alu_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [FUNC_W-1:0] in_f,
    input  logic              in_use_prev,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [FUNC_W-1:0] alu_f,
    input  logic [DATA_W-1:0] alu_r,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_r,
    output logic              out_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    cmd_t              push_cmd;
    cmd_t              head_cmd;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              push;
    logic              fire;
    logic              rdy_en_q;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_r_q, out_r_d;
    logic              out_err_q, out_err_d;
    logic [DATA_W-1:0] head_a;

    assign push_cmd = '{a: in_a, b: in_b, f: in_f, use_prev: in_use_prev};

    // rdy_en_q keeps in_ready low through reset and for the release cycle.
    assign in_ready = rdy_en_q && (fifo_count < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign fire     = !fifo_empty && (!out_valid_q || out_ready);

    alu_issue_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (push_cmd),
        .pop_i   (fire),
        .rdata_o (head_cmd),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

`ifdef ALU_ISSUE_FWD_EN
    logic [DATA_W-1:0] prev_r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_r_q <= '0;
        end else if (fire) begin
            prev_r_q <= alu_r;
        end
    end

    assign head_a = head_cmd.use_prev ? prev_r_q : head_cmd.a;
`else
    logic unused_use_prev;

    assign unused_use_prev = head_cmd.use_prev;
    assign head_a          = head_cmd.a;
`endif

    assign alu_a = fifo_empty ? '0 : head_a;
    assign alu_b = fifo_empty ? '0 : head_cmd.b;
    assign alu_f = fifo_empty ? '0 : head_cmd.f;

    always_comb begin
        out_valid_d = out_valid_q;
        out_r_d     = out_r_q;
        out_err_d   = out_err_q;
        if (fire) begin
            out_valid_d = 1'b1;
            if (f_is_legal(alu_f)) begin
                out_r_d   = alu_r;
                out_err_d = 1'b0;
            end else begin
                out_r_d   = '0;
                out_err_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdy_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_err_q   <= 1'b0;
        end else begin
            rdy_en_q    <= 1'b1;
            out_valid_q <= out_valid_d;
            out_r_q     <= out_r_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_r     = out_r_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed vector table, multi-cycle
// sequences, and a randomized run against a queue-based result model.
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_f;
    logic        in_use_prev;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_f;
    logic [31:0] alu_r;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_r;
    logic        out_err;

    int n_tests = 0;
    int n_fail  = 0;

    alu_issue #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_f        (in_f),
        .in_use_prev (in_use_prev),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_f       (alu_f),
        .alu_r       (alu_r),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_r       (out_r),
        .out_err     (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU; reserved codes return a data-dependent value the DUT must drop.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] f);
        case (f)
            3'd0:       return a + b;
            3'd1:       return a + 32'd1;
            3'd2:       return a - b;
            3'd3:       return a - 32'd1;
            3'd4, 3'd5: return 32'(a[15:0]) * 32'(b[15:0]);
            default:    return a ^ b ^ 32'hA5A5_0F0F;
        endcase
    endfunction

    always_comb alu_r = alu_fn(alu_a, alu_b, alu_f);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input logic up);
        in_valid    = v;
        in_a        = a;
        in_b        = b;
        in_f        = f;
        in_use_prev = up;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic [31:0] r;
        logic        err;
    } vec_t;

    vec_t vecs[10];
    logic [32:0] exp_q[$];
    logic [32:0] head;
    logic [31:0] prev_m;
    logic [31:0] raw;
    logic [31:0] op_a;
    logic [31:0] fwd_exp;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{a: 32'd5,          b: 32'd3,          f: 3'b000, r: 32'd8,          err: 1'b0};
        vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'd2,          f: 3'b000, r: 32'd1,          err: 1'b0};
        vecs[2] = '{a: 32'hFFFF_FFFF,  b: 32'd7,          f: 3'b001, r: 32'd0,          err: 1'b0};
        vecs[3] = '{a: 32'd3,          b: 32'd5,          f: 3'b010, r: 32'hFFFF_FFFE,  err: 1'b0};
        vecs[4] = '{a: 32'd0,          b: 32'd9,          f: 3'b011, r: 32'hFFFF_FFFF,  err: 1'b0};
        vecs[5] = '{a: 32'h0001_0003,  b: 32'h0002_0004,  f: 3'b100, r: 32'd12,         err: 1'b0};
        vecs[6] = '{a: 32'h1234_FFFF,  b: 32'h5678_FFFF,  f: 3'b101, r: 32'hFFFE_0001,  err: 1'b0};
        vecs[7] = '{a: 32'd9,          b: 32'd9,          f: 3'b111, r: 32'd0,          err: 1'b1};
        vecs[8] = '{a: 32'd1,          b: 32'd2,          f: 3'b110, r: 32'd0,          err: 1'b1};
        vecs[9] = '{a: 32'd100,        b: 32'd1,          f: 3'b011, r: 32'd99,         err: 1'b0};

        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0);

        // Reset state
        repeat (3) step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_r", out_r, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_alu_f", alu_f, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_low", in_ready, 0);
        step();
        chk("rel_in_ready_high", in_ready, 1);

        // Single commands: accept at edge N, valid after N+1, consumed at N+2
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].f, 1'b0);
            step();
            drive(1'b0, '0, '0, '0, 1'b0);
            chk($sformatf("vec%0d_valid_n", i), out_valid, 0);
            step();
            chk($sformatf("vec%0d_valid_n1", i), out_valid, 1);
            chk($sformatf("vec%0d_r", i), out_r, vecs[i].r);
            chk($sformatf("vec%0d_err", i), out_err, 32'(vecs[i].err));
            step();
            chk($sformatf("vec%0d_valid_n2", i), out_valid, 0);
        end

        // Fill under backpressure: one result parks in the output stage, four in the FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fill%0d_in_ready", i), in_ready, 1);
            drive(1'b1, 32'(i + 1), 32'd10, 3'b000, 1'b0);
            step();
        end
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        chk("full_out_r", out_r, 32'd11);
        drive(1'b1, 32'd99, 32'd99, 3'b000, 1'b0);
        step();
        step();
        drive(1'b0, '0, '0, '0, 1'b0);
        chk("stall_out_r", out_r, 32'd11);
        chk("stall_out_valid", out_valid, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("drain%0d_valid", i), out_valid, 1);
            chk($sformatf("drain%0d_r", i), out_r, 32'(11 + i));
            step();
        end
        chk("drain_end_valid", out_valid, 0);

        // Forwarding pair
`ifdef ALU_ISSUE_FWD_EN
        fwd_exp = 32'hFFFF_FFFB;
`else
        fwd_exp = 32'd67;
`endif
        drive(1'b1, 32'd2, 32'd3, 3'b000, 1'b0);
        step();
        drive(1'b1, 32'd77, 32'd10, 3'b010, 1'b1);
        step();
        drive(1'b0, '0, '0, '0, 1'b0);
        chk("fwd_op1_r", out_r, 32'd5);
        step();
        chk("fwd_op2_valid", out_valid, 1);
        chk("fwd_op2_r", out_r, fwd_exp);
        step();
        chk("fwd_idle_valid", out_valid, 0);

        // Mid-operation reset with three commands in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(i + 1), 32'd1, 3'b000, 1'b0);
            step();
        end
        drive(1'b0, '0, '0, '0, 1'b0);
        chk("mid_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_out_r", out_r, 0);
        step();
        chk("mid_post_in_ready", in_ready, 1);
        chk("mid_post_valid", out_valid, 0);
        chk("mid_post_alu_a", alu_a, 0);
        chk("mid_post_alu_f", alu_f, 0);
        out_ready = 1'b1;
        repeat (3) step();
        chk("mid_no_stale", out_valid, 0);

        // Randomized traffic against the in-order result model
        prev_m = '0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            drive(($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom(),
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom(),
                  3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)));
            out_ready = ($urandom_range(0, 9) < 6);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rand_unexpected_valid", out_valid, 0);
                end else begin
                    head = exp_q[0];
                    chk("rand_r", out_r, head[31:0]);
                    chk("rand_err", out_err, 32'(head[32]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
`ifdef ALU_ISSUE_FWD_EN
                op_a = in_use_prev ? prev_m : in_a;
`else
                op_a = in_a;
`endif
                raw    = alu_fn(op_a, in_b, in_f);
                prev_m = raw;
                if (in_f[2:1] == 2'b11) exp_q.push_back({1'b1, 32'd0});
                else                    exp_q.push_back({1'b0, raw});
            end
            step();
        end

        drive(1'b0, '0, '0, '0, 1'b0);
        out_ready = 1'b1;
        for (int g = 0; g < 40 && (exp_q.size() != 0 || out_valid); g++) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("drain_unexpected_valid", out_valid, 0);
                end else begin
                    head = exp_q.pop_front();
                    chk("drain_r", out_r, head[31:0]);
                    chk("drain_err", out_err, 32'(head[32]));
                end
            end
            step();
        end
        chk("rand_queue_empty", 32'(exp_q.size()), 0);
        chk("rand_final_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
